// File: rtl/bsg_cache_sbuf_pkg.sv
// Shared types for the store-buffer controller: drain FSM states and requester index.
package bsg_cache_sbuf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        STARVE = 2'd2,
        FLUSH  = 2'd3
    } sbuf_state_e;

    typedef logic sbuf_req_idx_t;

    // rr_last starts on requester 1 so requester 0 wins the first tie.
    localparam sbuf_req_idx_t RR_RESET_LAST = 1'b1;

endpackage

// File: rtl/bsg_cache_sbuf_rr_arb.sv
// Two-way round-robin arbiter; the grant already includes the requester's valid,
// so a grant is an accepted transfer and advances rr_last.
module bsg_cache_sbuf_rr_arb
    import bsg_cache_sbuf_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       en_i,
    input  logic [1:0] v_i,
    output logic [1:0] grant_o
);

    sbuf_req_idx_t rr_last_q, rr_last_d;

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            case (v_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = rr_last_q ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (grant_o[0]) begin
            rr_last_d = 1'b0;
        end else if (grant_o[1]) begin
            rr_last_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_last_q <= RR_RESET_LAST;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/bsg_cache_sbuf_ctrl.sv
// Store-buffer controller: arbitrates writes into the 2-entry buffer queue and
// drains its head to the shared data-memory port, stalling the pipeline on starvation.
//
//   state  | meaning
//   IDLE   | nothing buffered (bypass writes may still issue directly)
//   DRAIN  | entries pending, issuing whenever the load pipeline leaves the port free
//   STARVE | drain deferred too long; pipeline stall requested until one write lands
//   FLUSH  | forced drain; enqueues blocked and pipeline stalled until queue is empty
module bsg_cache_sbuf_ctrl
    import bsg_cache_sbuf_pkg::*;
#(
    parameter  int data_width_p   = 16,
    parameter  int starve_limit_p = 8,
    localparam int ctr_width_p    = $clog2(starve_limit_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [1:0]                req_v_i,
    input  logic [2*data_width_p-1:0] req_data_i,
    output logic [1:0]                req_ready_o,
    output logic                      q_v_o,
    output logic [data_width_p-1:0]   q_data_o,
    input  logic                      q_full_i,
    input  logic                      q_empty_i,
    input  logic                      q_v_i,
    input  logic [data_width_p-1:0]   q_data_i,
    output logic                      q_yumi_o,
    input  logic                      mem_busy_i,
    output logic                      mem_v_o,
    output logic [data_width_p-1:0]   mem_data_o,
    input  logic                      mem_yumi_i,
    input  logic                      drain_i,
    output logic                      stall_pipe_o,
    output logic                      idle_o
);

    localparam logic [ctr_width_p-1:0] STARVE_LIMIT = ctr_width_p'(starve_limit_p);

    sbuf_state_e            state_q, state_d;
    logic [ctr_width_p-1:0] starve_cnt_q, starve_cnt_d;
    logic                   stall_q, stall_d;
    logic                   arb_en;
    logic                   drain_waiting;

    // Grant is never tied to a same-cycle dequeue: full blocks enqueue outright.
    assign arb_en = !q_full_i && (state_q != FLUSH);

    bsg_cache_sbuf_rr_arb u_rr_arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (arb_en),
        .v_i       (req_v_i),
        .grant_o   (req_ready_o)
    );

    assign q_v_o    = |req_ready_o;
    assign q_data_o = req_ready_o[1] ? req_data_i[2*data_width_p-1:data_width_p]
                                     : req_data_i[data_width_p-1:0];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            stall_q      <= stall_d;
        end
    end

    assign drain_waiting = q_v_i && mem_busy_i;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            IDLE: begin
                starve_cnt_d = '0;
                if (drain_i && !q_empty_i) begin
                    state_d = FLUSH;
                end else if (q_v_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (q_yumi_o) begin
                    starve_cnt_d = '0;
                end else if (drain_waiting && (starve_cnt_q != STARVE_LIMIT)) begin
                    starve_cnt_d = starve_cnt_q + ctr_width_p'(1);
                end
                if (drain_i) begin
                    state_d = FLUSH;
                end else if (starve_cnt_d == STARVE_LIMIT) begin
                    state_d = STARVE;
                end else if (!q_v_i) begin
                    state_d = IDLE;
                end
            end
            STARVE: begin
                if (q_yumi_o) begin
                    starve_cnt_d = '0;
                    state_d      = DRAIN;
                end
                if (drain_i) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (q_yumi_o) begin
                    starve_cnt_d = '0;
                end
                if (q_empty_i && !mem_v_o) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                starve_cnt_d = '0;
            end
        endcase
        // Stall follows the next state so it drops the cycle after the releasing write.
        stall_d = (state_d == STARVE) || (state_d == FLUSH);
    end

    always_comb begin
        mem_v_o      = q_v_i && !mem_busy_i;
        mem_data_o   = q_data_i;
        q_yumi_o     = mem_v_o && mem_yumi_i;
        stall_pipe_o = stall_q;
        idle_o       = (state_q == IDLE) && q_empty_i;
    end

endmodule

// File: tb/tb_bsg_cache_sbuf_ctrl.sv
// Bench for the store-buffer controller: arbitration vector table, then a queue
// model plus write-order scoreboard for the starvation, flush and reset sequences.
module tb_bsg_cache_sbuf_ctrl;

    localparam int W   = 16;
    localparam int LIM = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [1:0]     req_v;
    logic [2*W-1:0] req_data;
    logic [1:0]     req_ready;
    logic           q_v_out;
    logic [W-1:0]   q_data_out;
    logic           q_full, q_empty, q_v_in;
    logic [W-1:0]   q_data_in;
    logic           q_yumi;
    logic           mem_busy, mem_v, mem_yumi, drain;
    logic [W-1:0]   mem_data;
    logic           stall_pipe, idle;

    // Queue environment: either a 2-entry model with bypass or raw table values.
    logic           use_model;
    logic           tv_full, tv_empty, tv_qv;
    logic [W-1:0]   tv_qdata;
    int             qcnt;
    logic [W-1:0]   qm0, qm1;

    assign q_full    = use_model ? (qcnt == 2) : tv_full;
    assign q_empty   = use_model ? (qcnt == 0) : tv_empty;
    assign q_v_in    = use_model ? ((qcnt != 0) || q_v_out) : tv_qv;
    assign q_data_in = use_model ? ((qcnt != 0) ? qm0 : q_data_out) : tv_qdata;

    bsg_cache_sbuf_ctrl #(.data_width_p(W), .starve_limit_p(LIM)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .req_v_i      (req_v),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .q_v_o        (q_v_out),
        .q_data_o     (q_data_out),
        .q_full_i     (q_full),
        .q_empty_i    (q_empty),
        .q_v_i        (q_v_in),
        .q_data_i     (q_data_in),
        .q_yumi_o     (q_yumi),
        .mem_busy_i   (mem_busy),
        .mem_v_o      (mem_v),
        .mem_data_o   (mem_data),
        .mem_yumi_i   (mem_yumi),
        .drain_i      (drain),
        .stall_pipe_o (stall_pipe),
        .idle_o       (idle)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] sb[$];

    typedef struct {
        logic [1:0] rv;
        logic       full, empty, qv, busy, myumi;
        logic [1:0] ready;
        logic       qvo, memv, qyumi, idle;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Called at the negedge: scoreboard and queue model, then advance one clock.
    task automatic tick();
        logic [W-1:0] n0, n1;
        int           ncnt;
        logic         enq, deq;
        n0   = qm0;
        n1   = qm1;
        ncnt = qcnt;
        enq  = q_v_out;
        deq  = q_yumi;
        if (use_model) begin
            for (int i = 0; i < 2; i++) begin
                if (req_v[i] && req_ready[i]) sb.push_back(req_data[i*W +: W]);
            end
            if (enq) chk("enq_while_full", 32'(qcnt == 2), 32'd0);
            if (mem_v && mem_yumi) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    chk("sb_write_data", 32'(mem_data), 32'(sb.pop_front()));
                end
            end
            if (enq && !deq) begin
                if (qcnt == 0) n0 = q_data_out; else n1 = q_data_out;
                ncnt = qcnt + 1;
            end else if (!enq && deq) begin
                n0   = qm1;
                ncnt = qcnt - 1;
            end else if (enq && deq) begin
                if (qcnt == 1) begin
                    n0 = q_data_out;
                end else if (qcnt == 2) begin
                    n0 = qm1;
                    n1 = q_data_out;
                end
            end
        end
        @(posedge clk);
        #1;
        qm0  = n0;
        qm1  = n1;
        qcnt = ncnt;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        req_v    = 2'b00;
        req_data = '0;
        mem_busy = 1'b0;
        mem_yumi = 1'b0;
        drain    = 1'b0;
        qcnt     = 0;
        qm0      = '0;
        qm1      = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // One entry held off by a busy port: 8 deferred cycles, then stall, then release.
    task automatic starve_run(input logic [W-1:0] d);
        req_v    = 2'b01;
        req_data = {16'h0, d};
        mem_busy = 1'b1;
        mem_yumi = 1'b0;
        @(negedge clk);
        chk("starve_enq_ready", 32'(req_ready), 32'h1);
        tick();
        req_v = 2'b00;
        for (int k = 1; k <= LIM; k++) begin
            @(negedge clk);
            chk($sformatf("starve_no_stall_%0d", k), 32'(stall_pipe), 32'd0);
            tick();
        end
        mem_busy = 1'b0;
        mem_yumi = 1'b1;
        @(negedge clk);
        chk("starve_stall_on", 32'(stall_pipe), 32'd1);
        chk("starve_issue", 32'(mem_v), 32'd1);
        tick();
        mem_yumi = 1'b0;
        @(negedge clk);
        chk("starve_stall_off", 32'(stall_pipe), 32'd0);
        tick();
    endtask

    initial begin
        use_model = 1'b0;
        tv_full   = 1'b0;
        tv_empty  = 1'b1;
        tv_qv     = 1'b0;
        tv_qdata  = '0;
        //          rv     full  empty qv    busy  myumi  ready  qvo   memv  qyumi idle
        tbl[0]  = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};

        do_reset();
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_q_v", 32'(q_v_out), 32'd0);
        chk("rst_mem_v", 32'(mem_v), 32'd0);
        chk("rst_stall", 32'(stall_pipe), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            req_v    = tbl[i].rv;
            req_data = {16'hB000 | 16'(i), 16'hA000 | 16'(i)};
            tv_full  = tbl[i].full;
            tv_empty = tbl[i].empty;
            tv_qv    = tbl[i].qv;
            tv_qdata = 16'hC000 | 16'(i);
            mem_busy = tbl[i].busy;
            mem_yumi = tbl[i].myumi;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].ready));
            chk($sformatf("vec%0d_q_v", i), 32'(q_v_out), 32'(tbl[i].qvo));
            chk($sformatf("vec%0d_mem_v", i), 32'(mem_v), 32'(tbl[i].memv));
            chk($sformatf("vec%0d_q_yumi", i), 32'(q_yumi), 32'(tbl[i].qyumi));
            chk($sformatf("vec%0d_idle", i), 32'(idle), 32'(tbl[i].idle));
            chk($sformatf("vec%0d_stall", i), 32'(stall_pipe), 32'd0);
            if (tbl[i].qvo)
                chk($sformatf("vec%0d_q_data", i), 32'(q_data_out),
                    32'(tbl[i].ready[1] ? (16'hB000 | 16'(i)) : (16'hA000 | 16'(i))));
            if (tbl[i].memv)
                chk($sformatf("vec%0d_mem_data", i), 32'(mem_data), 32'(16'hC000 | 16'(i)));
            @(posedge clk);
            #1;
        end

        use_model = 1'b1;
        do_reset();

        // Bypass: accepted and written to memory in the same cycle.
        req_v    = 2'b01;
        req_data = {16'h0, 16'h1111};
        mem_yumi = 1'b1;
        @(negedge clk);
        chk("bypass_ready", 32'(req_ready), 32'h1);
        chk("bypass_q_v", 32'(q_v_out), 32'd1);
        chk("bypass_mem_v", 32'(mem_v), 32'd1);
        chk("bypass_q_yumi", 32'(q_yumi), 32'd1);
        tick();
        req_v    = 2'b00;
        mem_yumi = 1'b0;
        repeat (2) begin
            @(negedge clk);
            tick();
        end

        starve_run(16'h2222);
        @(negedge clk);
        chk("after_starve_idle", 32'(idle), 32'd1);
        tick();

        // Forced flush of two buffered entries.
        mem_busy = 1'b1;
        req_v    = 2'b01;
        req_data = {16'h0, 16'h3331};
        @(negedge clk);
        tick();
        req_v    = 2'b10;
        req_data = {16'h3332, 16'h0};
        @(negedge clk);
        tick();
        req_v = 2'b00;
        drain = 1'b1;
        @(negedge clk);
        chk("flush_entry_full", 32'(q_full), 32'd1);
        tick();
        drain    = 1'b0;
        req_v    = 2'b11;
        req_data = {16'h9999, 16'h8888};
        mem_busy = 1'b0;
        mem_yumi = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("flush_ready_%0d", k), 32'(req_ready), 32'd0);
            chk($sformatf("flush_stall_%0d", k), 32'(stall_pipe), 32'd1);
            chk($sformatf("flush_mem_v_%0d", k), 32'(mem_v), (k < 2) ? 32'd1 : 32'd0);
            chk($sformatf("flush_idle_%0d", k), 32'(idle), 32'd0);
            tick();
        end
        req_v    = 2'b00;
        mem_yumi = 1'b0;
        @(negedge clk);
        chk("flush_done_idle", 32'(idle), 32'd1);
        chk("flush_done_stall", 32'(stall_pipe), 32'd0);
        tick();
        chk("flush_sb_drained", 32'(sb.size()), 32'd0);

        // Async reset in the middle of a starved drain with two entries.
        mem_busy = 1'b1;
        req_v    = 2'b01;
        req_data = {16'h0, 16'h4441};
        @(negedge clk);
        tick();
        req_v    = 2'b10;
        req_data = {16'h4442, 16'h0};
        @(negedge clk);
        tick();
        req_v = 2'b00;
        repeat (LIM - 1) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        chk("pre_reset_stall", 32'(stall_pipe), 32'd1);
        chk("pre_reset_idle", 32'(idle), 32'd0);
        #2;
        reset_n = 1'b0;
        qcnt    = 0;
        #1;
        chk("async_rst_stall", 32'(stall_pipe), 32'd0);
        chk("async_rst_idle", 32'(idle), 32'd1);
        chk("async_rst_mem_v", 32'(mem_v), 32'd0);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        mem_busy = 1'b0;
        sb.delete();
        @(negedge clk);
        tick();

        // A fresh full-length starvation window shows the counter restarted at zero.
        starve_run(16'h5555);
        @(negedge clk);
        tick();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
